// File: rtl/spu_result_pipe_if.sv
// spu_result_pipe_if: data, control, branch-redirect and forwarding signals of
// the SPU dual-issue result pipeline. The pipeline itself uses the slave modport.
interface spu_result_pipe_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int UID_W  = 3
);
  // Pipeline control
  logic              stall;
  logic              flush;
  // Entry into stage 0
  logic [ADDR_W-1:0] in_rtaddr_e;
  logic [ADDR_W-1:0] in_rtaddr_o;
  logic              in_wreg_e;
  logic              in_wreg_o;
  logic [DATA_W-1:0] in_rt_e;
  logic [DATA_W-1:0] in_rt_o;
  logic [UID_W-1:0]  in_uid_e;
  logic [UID_W-1:0]  in_uid_o;
  logic [31:0]       in_mem_addr_o;
  logic              in_branch_flag;
  logic [31:0]       in_branch_target;
  logic [31:0]       in_link_addr;
  logic              in_delayslot;
  // Writeback (last stage)
  logic [ADDR_W-1:0] out_rtaddr_e;
  logic [ADDR_W-1:0] out_rtaddr_o;
  logic              out_wreg_e;
  logic              out_wreg_o;
  logic [DATA_W-1:0] out_rt_e;
  logic [DATA_W-1:0] out_rt_o;
  logic [UID_W-1:0]  out_uid_e;
  logic [UID_W-1:0]  out_uid_o;
  logic [31:0]       out_mem_addr_o;
  // Redirect to the PC register
  logic              br_flag;
  logic [31:0]       br_target;
  logic              br_delayslot;
  // Forwarding lookup
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  stall, flush,
    input  in_rtaddr_e, in_rtaddr_o, in_wreg_e, in_wreg_o, in_rt_e, in_rt_o,
    input  in_uid_e, in_uid_o, in_mem_addr_o,
    input  in_branch_flag, in_branch_target, in_link_addr, in_delayslot,
    input  fwd_addr,
    output out_rtaddr_e, out_rtaddr_o, out_wreg_e, out_wreg_o, out_rt_e, out_rt_o,
    output out_uid_e, out_uid_o, out_mem_addr_o,
    output br_flag, br_target, br_delayslot,
    output fwd_hit, fwd_data
  );

  modport master (
    output stall, flush,
    output in_rtaddr_e, in_rtaddr_o, in_wreg_e, in_wreg_o, in_rt_e, in_rt_o,
    output in_uid_e, in_uid_o, in_mem_addr_o,
    output in_branch_flag, in_branch_target, in_link_addr, in_delayslot,
    output fwd_addr,
    input  out_rtaddr_e, out_rtaddr_o, out_wreg_e, out_wreg_o, out_rt_e, out_rt_o,
    input  out_uid_e, out_uid_o, out_mem_addr_o,
    input  br_flag, br_target, br_delayslot,
    input  fwd_hit, fwd_data
  );
endinterface

// File: rtl/spu_result_pipe.sv
// spu_result_pipe: DEPTH-stage dual-issue (even/odd) result pipeline with stall,
// partial flush of the first FLUSH_DEPTH stages, branch-and-link value
// substitution on entry, a registered branch redirect, and a forwarding lookup.
// Optional feature macro: RESULT_PIPE_FWD_EN builds the forwarding comparators;
// without it fwd_hit/fwd_data are constant 0.
module spu_result_pipe #(
  parameter int DEPTH       = 4,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 7,
  parameter int UID_W       = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  spu_result_pipe_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] rtaddr_e;
    logic              wreg_e;
    logic [DATA_W-1:0] rt_e;
    logic [UID_W-1:0]  uid_e;
    logic [ADDR_W-1:0] rtaddr_o;
    logic              wreg_o;
    logic [DATA_W-1:0] rt_o;
    logic [UID_W-1:0]  uid_o;
    logic [31:0]       mem_addr_o;
  } stage_t;

  localparam stage_t STAGE_ZERO = '0;

  stage_t      r_stage      [DEPTH];
  stage_t      w_stage_next [DEPTH];
  stage_t      w_in_entry;
  logic        r_br_flag;
  logic [31:0] r_br_target;
  logic        r_br_delayslot;

  // Build the incoming entry; a taken branch replaces the odd value with the
  // link address in the preferred-slot word
  always_comb begin
    w_in_entry            = STAGE_ZERO;
    w_in_entry.rtaddr_e   = bus.in_rtaddr_e;
    w_in_entry.wreg_e     = bus.in_wreg_e;
    w_in_entry.rt_e       = bus.in_rt_e;
    w_in_entry.uid_e      = bus.in_uid_e;
    w_in_entry.rtaddr_o   = bus.in_rtaddr_o;
    w_in_entry.wreg_o     = bus.in_wreg_o;
    w_in_entry.rt_o       = bus.in_branch_flag ? {bus.in_link_addr, {(DATA_W-32){1'b0}}}
                                               : bus.in_rt_o;
    w_in_entry.uid_o      = bus.in_uid_o;
    w_in_entry.mem_addr_o = bus.in_mem_addr_o;
  end

  // Per-stage next value. While stalled, flushed stages are cleared in place.
  // While advancing, a stage is cleared when its source was inside the flush
  // window (for stage 0 the source is the incoming entry).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    localparam bit KILL_HOLD = (gi < FLUSH_DEPTH);
    localparam bit KILL_SRC  = (gi == 0) ? (FLUSH_DEPTH > 0) : (gi <= FLUSH_DEPTH);
    stage_t w_src;
    if (gi == 0) begin : g_head
      assign w_src = w_in_entry;
    end else begin : g_body
      assign w_src = r_stage[gi-1];
    end
    assign w_stage_next[gi] = bus.stall
        ? ((bus.flush && KILL_HOLD) ? STAGE_ZERO : r_stage[gi])
        : ((bus.flush && KILL_SRC)  ? STAGE_ZERO : w_src);
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= STAGE_ZERO;
    end else begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= w_stage_next[k];
    end
  end

  // Branch redirect sideband: one-cycle register, held during stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_flag      <= 1'b0;
      r_br_target    <= 32'h0;
      r_br_delayslot <= 1'b0;
    end else if (!bus.stall) begin
      r_br_flag      <= bus.in_branch_flag & ~bus.flush;
      r_br_target    <= bus.in_branch_target;
      r_br_delayslot <= bus.in_delayslot;
    end
  end

  assign bus.out_rtaddr_e   = r_stage[DEPTH-1].rtaddr_e;
  assign bus.out_wreg_e     = r_stage[DEPTH-1].wreg_e;
  assign bus.out_rt_e       = r_stage[DEPTH-1].rt_e;
  assign bus.out_uid_e      = r_stage[DEPTH-1].uid_e;
  assign bus.out_rtaddr_o   = r_stage[DEPTH-1].rtaddr_o;
  assign bus.out_wreg_o     = r_stage[DEPTH-1].wreg_o;
  assign bus.out_rt_o       = r_stage[DEPTH-1].rt_o;
  assign bus.out_uid_o      = r_stage[DEPTH-1].uid_o;
  assign bus.out_mem_addr_o = r_stage[DEPTH-1].mem_addr_o;
  assign bus.br_flag        = r_br_flag;
  assign bus.br_target      = r_br_target;
  assign bus.br_delayslot   = r_br_delayslot;

`ifdef RESULT_PIPE_FWD_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Forwarding lookup: scan oldest to youngest so the youngest match wins;
  // odd is tested before even so even wins within a stage
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_stage[k].wreg_o && (r_stage[k].rtaddr_o == bus.fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_stage[k].rt_o;
      end
      if (r_stage[k].wreg_e && (r_stage[k].rtaddr_e == bus.fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_stage[k].rt_e;
      end
    end
  end

  assign bus.fwd_hit  = w_fwd_hit;
  assign bus.fwd_data = w_fwd_data;
`else
  logic [ADDR_W-1:0] w_fwd_addr_unused;
  assign w_fwd_addr_unused = bus.fwd_addr;
  assign bus.fwd_hit       = 1'b0;
  assign bus.fwd_data      = '0;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
// tb_spu_result_pipe: table-driven and randomized checks of spu_result_pipe
// (DEPTH=4, FLUSH_DEPTH=2) against a queue-based reference model.
`timescale 1ns/1ps
module tb_spu_result_pipe;
  localparam int DEPTH       = 4;
  localparam int DATA_W      = 128;
  localparam int ADDR_W      = 7;
  localparam int UID_W       = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int NV          = 23;
`ifdef RESULT_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] rtaddr_e;
    logic              wreg_e;
    logic [DATA_W-1:0] rt_e;
    logic [UID_W-1:0]  uid_e;
    logic [ADDR_W-1:0] rtaddr_o;
    logic              wreg_o;
    logic [DATA_W-1:0] rt_o;
    logic [UID_W-1:0]  uid_o;
    logic [31:0]       mem_addr_o;
  } ent_t;

  typedef struct {
    bit         stall;
    bit         flush;
    logic [6:0] addr_e;
    bit         wreg_e;
    bit         br;
    logic [6:0] x_addr_e;
    bit         x_wreg_e;
    bit         x_br;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  ent_t        m_pipe[$];
  logic        m_br_flag;
  logic [31:0] m_br_target;
  logic        m_br_ds;
  vec_t        vt[NV];

  spu_result_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .UID_W(UID_W)) bus();

  spu_result_pipe #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UID_W(UID_W), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit st, bit fl, int a, bit w, bit b, int xa, bit xw, bit xb);
    vec_t v;
    v.stall = st; v.flush = fl; v.addr_e = 7'(a); v.wreg_e = w; v.br = b;
    v.x_addr_e = 7'(xa); v.x_wreg_e = xw; v.x_br = xb;
    return v;
  endfunction

  function automatic ent_t dut_out();
    ent_t e;
    e.rtaddr_e = bus.out_rtaddr_e; e.wreg_e = bus.out_wreg_e;
    e.rt_e = bus.out_rt_e; e.uid_e = bus.out_uid_e;
    e.rtaddr_o = bus.out_rtaddr_o; e.wreg_o = bus.out_wreg_o;
    e.rt_o = bus.out_rt_o; e.uid_o = bus.out_uid_o;
    e.mem_addr_o = bus.out_mem_addr_o;
    return e;
  endfunction

  // What the pipe should accept this cycle, including link substitution
  function automatic ent_t in_entry();
    ent_t e;
    e.rtaddr_e = bus.in_rtaddr_e; e.wreg_e = bus.in_wreg_e;
    e.rt_e = bus.in_rt_e; e.uid_e = bus.in_uid_e;
    e.rtaddr_o = bus.in_rtaddr_o; e.wreg_o = bus.in_wreg_o;
    e.rt_o = bus.in_branch_flag ? {bus.in_link_addr, 96'h0} : bus.in_rt_o;
    e.uid_o = bus.in_uid_o;
    e.mem_addr_o = bus.in_mem_addr_o;
    return e;
  endfunction

  task automatic model_reset();
    m_pipe = {};
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back(ent_t'(0));
    m_br_flag = 1'b0; m_br_target = 32'h0; m_br_ds = 1'b0;
  endtask

  // Queue model: index 0 is the youngest entry, index DEPTH-1 is at writeback
  task automatic model_step();
    ent_t nw;
    if (bus.flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) m_pipe[i] = '0;
    end
    if (!bus.stall) begin
      nw = in_entry();
      if (bus.flush && FLUSH_DEPTH > 0) nw = '0;
      m_pipe.push_front(nw);
      void'(m_pipe.pop_back());
      m_br_flag   = bus.in_branch_flag & ~bus.flush;
      m_br_target = bus.in_branch_target;
      m_br_ds     = bus.in_delayslot;
    end
  endtask

  task automatic model_fwd(output logic hit, output logic [DATA_W-1:0] data);
    hit = 1'b0; data = '0;
    if (FWD) begin
      for (int i = 0; i < DEPTH && !hit; i++) begin
        if (m_pipe[i].wreg_e && m_pipe[i].rtaddr_e == bus.fwd_addr) begin
          hit = 1'b1; data = m_pipe[i].rt_e;
        end else if (m_pipe[i].wreg_o && m_pipe[i].rtaddr_o == bus.fwd_addr) begin
          hit = 1'b1; data = m_pipe[i].rt_o;
        end
      end
    end
  endtask

  task automatic check_all();
    logic              h;
    logic [DATA_W-1:0] d;
    model_fwd(h, d);
    chk("out", 320'(dut_out()), 320'(m_pipe[DEPTH-1]));
    chk("br", 320'({bus.br_flag, bus.br_target, bus.br_delayslot}),
        320'({m_br_flag, m_br_target, m_br_ds}));
    chk("fwd", 320'({bus.fwd_hit, bus.fwd_data}), 320'({h, d}));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    $display("cyc=%0d stall=%b flush=%b out_e=%0d/%b out_o=%0d/%b br=%b/%h fwd=%b/%h",
             cyc, bus.stall, bus.flush, bus.out_rtaddr_e, bus.out_wreg_e, bus.out_rtaddr_o,
             bus.out_wreg_o, bus.br_flag, bus.br_target, bus.fwd_hit, bus.fwd_data[31:0]);
  endtask

  task automatic set_idle();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.in_rtaddr_e = '0; bus.in_rtaddr_o = '0; bus.in_wreg_e = 1'b0; bus.in_wreg_o = 1'b0;
    bus.in_rt_e = '0; bus.in_rt_o = '0; bus.in_uid_e = '0; bus.in_uid_o = '0;
    bus.in_mem_addr_o = '0; bus.in_branch_flag = 1'b0; bus.in_branch_target = '0;
    bus.in_link_addr = '0; bus.in_delayslot = 1'b0;
  endtask

  task automatic set_random(input bit calm);
    bus.stall = calm ? 1'b0 : ($urandom_range(0, 4) == 0);
    bus.flush = calm ? 1'b0 : ($urandom_range(0, 9) == 0);
    bus.in_rtaddr_e = 7'($urandom_range(0, 15));
    bus.in_rtaddr_o = 7'($urandom_range(0, 15));
    bus.in_wreg_e = calm ? 1'b1 : 1'($urandom_range(0, 1));
    bus.in_wreg_o = 1'($urandom_range(0, 1));
    bus.in_rt_e = {$urandom, $urandom, $urandom, $urandom};
    bus.in_rt_o = {$urandom, $urandom, $urandom, $urandom};
    bus.in_uid_e = 3'($urandom_range(0, 7));
    bus.in_uid_o = 3'($urandom_range(0, 7));
    bus.in_mem_addr_o = $urandom;
    bus.in_branch_flag = ($urandom_range(0, 3) == 0);
    bus.in_branch_target = $urandom;
    bus.in_link_addr = $urandom;
    bus.in_delayslot = 1'($urandom_range(0, 1));
    bus.fwd_addr = 7'($urandom_range(0, 15));
  endtask

  initial begin
    // stall/flush, even addr/wreg, branch -> expected out addr/wreg and br_flag
    vt[0]  = mkv(0, 0, 5, 1, 0, 0, 0, 0);
    vt[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mkv(0, 0, 0, 0, 0, 5, 1, 0);
    vt[4]  = mkv(0, 0, 6, 1, 0, 0, 0, 0);
    vt[5]  = mkv(1, 0, 15, 1, 0, 0, 0, 0);
    vt[6]  = mkv(1, 0, 15, 1, 0, 0, 0, 0);
    vt[7]  = mkv(1, 0, 15, 1, 0, 0, 0, 0);
    vt[8]  = mkv(0, 0, 7, 1, 0, 0, 0, 0);
    vt[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = mkv(0, 0, 0, 0, 0, 6, 1, 0);
    vt[11] = mkv(0, 0, 0, 0, 0, 7, 1, 0);
    vt[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[13] = mkv(0, 0, 1, 1, 0, 0, 0, 0);
    vt[14] = mkv(0, 0, 2, 1, 0, 0, 0, 0);
    vt[15] = mkv(0, 0, 3, 1, 0, 0, 0, 0);
    vt[16] = mkv(0, 0, 4, 1, 0, 1, 1, 0);
    vt[17] = mkv(0, 1, 9, 1, 1, 2, 1, 0);
    vt[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[19] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vt[21] = mkv(0, 0, 0, 0, 1, 0, 0, 1);
    vt[22] = mkv(1, 0, 0, 0, 0, 0, 0, 1);

    set_idle();
    bus.fwd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Table: latency, stall, flush window, branch sideband
    for (int r = 0; r < NV; r++) begin
      set_idle();
      bus.stall = vt[r].stall;
      bus.flush = vt[r].flush;
      bus.in_rtaddr_e = vt[r].addr_e;
      bus.in_wreg_e = vt[r].wreg_e;
      bus.in_rt_e = {16{1'b0, vt[r].addr_e}};
      bus.in_branch_flag = vt[r].br;
      bus.in_branch_target = 32'h1000 + 32'(r);
      tick();
      chk("tbl_addr_e", 320'(bus.out_rtaddr_e), 320'(vt[r].x_addr_e));
      chk("tbl_wreg_e", 320'(bus.out_wreg_e), 320'(vt[r].x_wreg_e));
      chk("tbl_br_flag", 320'(bus.br_flag), 320'(vt[r].x_br));
    end

    // Link substitution on the odd value
    set_idle();
    bus.in_rtaddr_o = 7'd3; bus.in_wreg_o = 1'b1; bus.in_rt_o = '1;
    bus.in_branch_flag = 1'b1; bus.in_link_addr = 32'h0000_0104; bus.in_branch_target = 32'h000d_ead0;
    tick();
    chk("link_br", 320'({bus.br_flag, bus.br_target}), 320'({1'b1, 32'h000d_ead0}));
    set_idle();
    repeat (3) tick();
    chk("link_rt_o", 320'(bus.out_rt_o), 320'({32'h0000_0104, 96'h0}));
    chk("link_wreg_o", 320'({bus.out_rtaddr_o, bus.out_wreg_o}), 320'({7'd3, 1'b1}));

    // Forwarding priority: stage 1 even r7=0xA over stage 3 odd r7=0xB
    set_idle();
    bus.in_rtaddr_o = 7'd7; bus.in_wreg_o = 1'b1; bus.in_rt_o = 128'hB;
    tick();
    set_idle();
    tick();
    bus.in_rtaddr_e = 7'd7; bus.in_wreg_e = 1'b1; bus.in_rt_e = 128'hA;
    tick();
    set_idle();
    tick();
    bus.fwd_addr = 7'd7;
    #1;
    chk("fwd_young", 320'({bus.fwd_hit, bus.fwd_data}), 320'({FWD, FWD ? 128'hA : 128'h0}));
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    set_idle();
    #1;
    chk("fwd_old", 320'({bus.fwd_hit, bus.fwd_data}), 320'({FWD, FWD ? 128'hB : 128'h0}));
    bus.fwd_addr = 7'd8;
    #1;
    chk("fwd_miss", 320'({bus.fwd_hit, bus.fwd_data}), 320'(0));

    // Randomized run against the model
    for (int i = 0; i < 300; i++) begin
      set_random(i >= 296);
      tick();
    end

    // Asynchronous reset between edges with a full pipe
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out", 320'(dut_out()), 320'(0));
    chk("arst_br", 320'({bus.br_flag, bus.br_target, bus.br_delayslot}), 320'(0));
    chk("arst_fwd", 320'({bus.fwd_hit, bus.fwd_data}), 320'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      set_random(1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
